// File: rtl/reaction_timer_if.sv
// reaction_timer_if
// Groups the player-facing signals of the reaction timer into one bundle.
//   lights     : 8-bit lamp pattern from the light sequencer (8'hFF all lit, 8'h00 out)
//   button     : raw player button, asynchronous to the clock, active-high
//   bcd        : last captured reaction time, 4 BCD digits in milliseconds
//   valid      : one-cycle pulse when bcd is reloaded
//   jump_start : sticky flag, the player pressed while all lamps were lit
//   busy       : high while a reaction is being timed
// The master modport drives lights/button and observes the results. The slave
// modport is the timer itself.
interface reaction_timer_if;
  logic [7:0]  lights;
  logic        button;
  logic [15:0] bcd;
  logic        valid;
  logic        jump_start;
  logic        busy;

  modport master (
    output lights,
    output button,
    input  bcd,
    input  valid,
    input  jump_start,
    input  busy
  );

  modport slave (
    input  lights,
    input  button,
    output bcd,
    output valid,
    output jump_start,
    output busy
  );
endinterface

// File: rtl/reaction_timer.sv
// reaction_timer
// Measures the time in milliseconds between the start lights going out and the
// player's button press. It also flags a jump start, which is a press made while
// all lamps are lit. The result is held as 4-digit BCD for the display stage.
//   MS_DIV : clock cycles per millisecond (1 or more)
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset, clears all state
//   tif    : slave side of reaction_timer_if (lights/button in,
//            bcd/valid/jump_start/busy out, all outputs registered)
module reaction_timer #(
  parameter int MS_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  reaction_timer_if.slave   tif
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(MS_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    TIMING
  } state_t;

  state_t          state_q, state_d;
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            s3_q, s3_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     live_q, live_d;
  logic [15:0]     bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic            jump_q, jump_d;
  logic            busy_q, busy_d;

  logic            rise;
  logic            wrap;

  // Decimal increment with per-digit carry. The count saturates at 9999
  // instead of rolling over, so a very slow player still gets a bounded result.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      return v;
    end
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A press only counts on its rising edge after synchronisation. This means
  // a button already held when the lamps change can never trigger anything.
  assign rise = s2_q & ~s3_q;
  assign wrap = (presc_q == PRESC_MAX);

  always_comb begin
    s1_d    = tif.button;
    s2_d    = s1_q;
    s3_d    = s2_q;
    state_d = state_q;
    presc_d = presc_q;
    live_d  = live_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    jump_d  = jump_q;

    case (state_q)
      IDLE: begin
        if (tif.lights == 8'hFF) begin
          state_d = ARMED;
          jump_d  = 1'b0;
        end
      end

      // A press here is a jump start. It takes priority over lights going
      // out on the same edge.
      ARMED: begin
        if (rise) begin
          jump_d  = 1'b1;
          state_d = IDLE;
        end else if (tif.lights == 8'h00) begin
          state_d = TIMING;
          presc_d = '0;
          live_d  = '0;
        end
      end

      // Capture uses live_q, the count before any increment on this edge,
      // so a press landing on a millisecond boundary reports the lower
      // value. A capture also wins over lights coming back on.
      TIMING: begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        if (wrap) begin
          live_d = bcd_inc(live_q);
        end
        if (rise) begin
          bcd_d   = live_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (tif.lights != 8'h00) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == TIMING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      presc_q <= '0;
      live_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      presc_q <= presc_d;
      live_q  <= live_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      jump_q  <= jump_d;
      busy_q  <= busy_d;
    end
  end

  assign tif.bcd        = bcd_q;
  assign tif.valid      = valid_q;
  assign tif.jump_start = jump_q;
  assign tif.busy       = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer
// Drives two reaction timers, one with MS_DIV=4 and one with MS_DIV=1, from the
// same lights/button stimulus. An edge-counting reference model predicts every
// output. The model is compared against both devices on every falling clock
// edge, and a set of hand-computed values pins the model in known scenarios.
module tb_reaction_timer;

  localparam int PH_IDLE   = 0;
  localparam int PH_ARMED  = 1;
  localparam int PH_TIMING = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] lights = 8'h00;
  logic       button = 1'b0;

  int errors = 0;
  int checks = 0;

  reaction_timer_if tif4();
  reaction_timer_if tif1();

  assign tif4.lights = lights;
  assign tif4.button = button;
  assign tif1.lights = lights;
  assign tif1.button = button;

  reaction_timer #(.MS_DIV(4)) dut4 (.clk(clk), .rst(rst), .tif(tif4));
  reaction_timer #(.MS_DIV(1)) dut1 (.clk(clk), .rst(rst), .tif(tif1));

  always #5 clk = ~clk;

  // The reference model counts clock edges and records when timing began.
  // Elapsed milliseconds come from plain division instead of a prescaler.
  int          ms_div [2] = '{4, 1};
  int          m_phase[2];
  int          m_et   [2];
  logic [15:0] m_bcd  [2];
  logic        m_valid[2];
  logic        m_js   [2];
  int          n_edge;
  logic        h1, h2, h3;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic modelReset();
    n_edge = 0;
    h1 = 1'b0;
    h2 = 1'b0;
    h3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = PH_IDLE;
      m_et[i]    = 0;
      m_bcd[i]   = 16'h0000;
      m_valid[i] = 1'b0;
      m_js[i]    = 1'b0;
    end
  endtask

  // A press first seen at edge E0 acts at edge E0+2. The button history is
  // kept as the samples taken at the last three edges.
  task automatic modelStep();
    logic rise;
    int   ms;
    rise = h2 & ~h3;
    n_edge++;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      if (m_phase[i] == PH_IDLE) begin
        if (lights == 8'hFF) begin
          m_phase[i] = PH_ARMED;
          m_js[i]    = 1'b0;
        end
      end else if (m_phase[i] == PH_ARMED) begin
        if (rise) begin
          m_js[i]    = 1'b1;
          m_phase[i] = PH_IDLE;
        end else if (lights == 8'h00) begin
          m_phase[i] = PH_TIMING;
          m_et[i]    = n_edge;
        end
      end else begin
        if (rise) begin
          ms = (n_edge - m_et[i] - 1) / ms_div[i];
          if (ms > 9999) ms = 9999;
          m_bcd[i]   = to_bcd(ms);
          m_valid[i] = 1'b1;
          m_phase[i] = PH_IDLE;
        end else if (lights != 8'h00) begin
          m_phase[i] = PH_IDLE;
        end
      end
    end
    h3 = h2;
    h2 = h1;
    h1 = button;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else     modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of both devices against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("bcd4",   tif4.bcd,               m_bcd[0]);
      checkOutput("valid4", 16'(tif4.valid),        16'(m_valid[0]));
      checkOutput("jump4",  16'(tif4.jump_start),   16'(m_js[0]));
      checkOutput("busy4",  16'(tif4.busy),         16'(m_phase[0] == PH_TIMING));
      checkOutput("bcd1",   tif1.bcd,               m_bcd[1]);
      checkOutput("valid1", 16'(tif1.valid),        16'(m_valid[1]));
      checkOutput("jump1",  16'(tif1.jump_start),   16'(m_js[1]));
      checkOutput("busy1",  16'(tif1.busy),         16'(m_phase[1] == PH_TIMING));
    end
  end

  // Waits n falling edges, so inputs always change away from the rising edge.
  task automatic applyStimulus(input logic [7:0] l, input logic b, input int n);
    lights = l;
    button = b;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset bcd",   tif4.bcd, 16'h0000);
    checkOutput("reset valid", 16'(tif4.valid), 16'h0000);
    checkOutput("reset jump",  16'(tif4.jump_start), 16'h0000);
    checkOutput("reset busy",  16'(tif4.busy), 16'h0000);
    rst = 1'b0;

    // After reset, lights out and a toggling button must not capture
    for (int i = 0; i < 8; i++) applyStimulus(8'h00, ~button, 1);
    applyStimulus(8'h00, 1'b0, 3);
    checkOutput("idle bcd",  tif4.bcd, 16'h0000);
    checkOutput("idle busy", 16'(tif4.busy), 16'h0000);

    // Normal run: the capture edge is Et+150
    for (int i = 0; i < 8; i++) applyStimulus(8'((16'h1 << (i + 1)) - 16'h1), 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 148);
    applyStimulus(8'h00, 1'b1, 2);
    checkOutput("normal busy before", 16'(tif4.busy), 16'h0001);
    checkOutput("normal valid before", 16'(tif4.valid), 16'h0000);
    @(negedge clk);
    checkOutput("normal bcd4", tif4.bcd, 16'h0037);
    checkOutput("normal bcd1", tif1.bcd, 16'h0149);
    checkOutput("normal valid", 16'(tif4.valid), 16'h0001);
    checkOutput("normal busy after", 16'(tif4.busy), 16'h0000);
    @(negedge clk);
    checkOutput("normal valid pulse", 16'(tif4.valid), 16'h0000);

    // Jump start
    applyStimulus(8'h00, 1'b0, 3);
    applyStimulus(8'hFF, 1'b0, 1);
    applyStimulus(8'hFF, 1'b1, 3);
    checkOutput("jump flag", 16'(tif4.jump_start), 16'h0001);
    checkOutput("jump valid", 16'(tif4.valid), 16'h0000);
    checkOutput("jump bcd", tif4.bcd, 16'h0037);
    applyStimulus(8'h00, 1'b1, 4);
    checkOutput("jump stays idle", 16'(tif4.busy), 16'h0000);
    checkOutput("jump sticky", 16'(tif4.jump_start), 16'h0001);
    applyStimulus(8'hFF, 1'b1, 1);
    checkOutput("jump cleared", 16'(tif4.jump_start), 16'h0000);

    // Abort with the button held
    applyStimulus(8'h00, 1'b1, 5);
    checkOutput("abort timing", 16'(tif4.busy), 16'h0001);
    applyStimulus(8'h01, 1'b1, 1);
    checkOutput("abort busy", 16'(tif4.busy), 16'h0000);
    checkOutput("abort valid", 16'(tif4.valid), 16'h0000);
    checkOutput("abort bcd", tif4.bcd, 16'h0037);
    applyStimulus(8'h01, 1'b0, 3);
    applyStimulus(8'h01, 1'b1, 4);
    checkOutput("idle press bcd", tif4.bcd, 16'h0037);
    checkOutput("idle press jump", 16'(tif4.jump_start), 16'h0000);

    // Press landing on the millisecond wrap at Et+8
    applyStimulus(8'h01, 1'b0, 3);
    applyStimulus(8'hFF, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 6);
    applyStimulus(8'h00, 1'b1, 3);
    checkOutput("coincide bcd4", tif4.bcd, 16'h0001);
    checkOutput("coincide bcd1", tif1.bcd, 16'h0007);
    checkOutput("coincide valid", 16'(tif4.valid), 16'h0001);

    // Saturation on the MS_DIV=1 device
    applyStimulus(8'h01, 1'b0, 3);
    applyStimulus(8'hFF, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 10010);
    applyStimulus(8'h00, 1'b1, 3);
    checkOutput("sat bcd1", tif1.bcd, 16'h9999);
    checkOutput("sat valid1", 16'(tif1.valid), 16'h0001);
    checkOutput("sat bcd4", tif4.bcd, 16'h2502);

    // Asynchronous reset in the middle of timing
    applyStimulus(8'h01, 1'b0, 3);
    applyStimulus(8'hFF, 1'b0, 1);
    applyStimulus(8'h00, 1'b0, 20);
    checkOutput("pre-reset busy", 16'(tif1.busy), 16'h0001);
    #2 rst = 1'b1;
    #1;
    checkOutput("async bcd1", tif1.bcd, 16'h0000);
    checkOutput("async busy1", 16'(tif1.busy), 16'h0000);
    checkOutput("async bcd4", tif4.bcd, 16'h0000);
    checkOutput("async busy4", 16'(tif4.busy), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(8'h00, ~button, 1);
    checkOutput("post-reset bcd", tif1.bcd, 16'h0000);
    checkOutput("post-reset busy", 16'(tif1.busy), 16'h0000);

    // Randomized segments of held light patterns and button toggles
    for (int seg = 0; seg < 250; seg++) begin
      int r;
      int len;
      r = $urandom_range(0, 9);
      if (r < 3)      lights = 8'hFF;
      else if (r < 7) lights = 8'h00;
      else            lights = 8'($urandom);
      len = $urandom_range(1, 20);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 5) == 0) button = ~button;
        @(negedge clk);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Measures player reaction time in milliseconds, from the F1 start lights going out to the player's button press. It sits directly downstream of the F1 light sequencer and consumes its 8-bit lamp output. It also detects jump starts, meaning a press made while all lamps are lit. The result is presented as 4-digit BCD for the display stage.

## Interface
- MS_DIV, default 1000: clk cycles per millisecond. Legal range is 1 or more. The prescaler width is $clog2(MS_DIV), with a minimum of 1 bit.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- lights  in  8  lamp pattern from the light sequencer; 8'hFF means all lit, 8'h00 means lights out.
- button  in  1  raw player button, asynchronous to clk, active-high.
- bcd  out  16  last captured reaction time: 4 BCD digits, [15:12] thousands down to [3:0] units, in ms.
- valid  out  1  one-cycle pulse when a new value is loaded into bcd.
- jump_start  out  1  sticky flag: the button was pressed while armed.
- busy  out  1  high while in TIMING.

## Operation
- Button path:
  - 2-flop synchronizer (s1, s2), then a delay flop s3.
  - rise = s2 & ~s3.
  - Only rising edges act. A button held across a state change never triggers.
- FSM states are IDLE, ARMED and TIMING. Reset state is IDLE.
- IDLE:
  - lights == 8'hFF -> ARMED; clear jump_start on that edge.
  - Button is ignored.
- ARMED:
  - rise -> set jump_start, go to IDLE; valid stays 0.
  - Else, lights == 8'h00 -> TIMING; clear the prescaler and the live BCD counter.
  - Other light patterns stay in ARMED.
  - If rise and lights == 8'h00 occur on the same edge, the jump start wins.
- TIMING:
  - Prescaler counts 0..MS_DIV-1 and wraps. On the wrap edge the live BCD counter increments.
  - The counter uses decimal carry per digit (9 -> 0, carry into the next digit).
  - It saturates at 16'h9999 and holds there.
  - rise -> bcd <= live count, valid = 1 for one cycle, go to IDLE.
  - lights != 8'h00 without a rise -> abort to IDLE. No valid, bcd unchanged.
  - rise and prescaler wrap on the same edge: capture the pre-increment value.
  - rise and lights going nonzero on the same edge: capture wins.
- bcd changes only on a capture. It holds the previous result across aborts and jump starts.
- busy = (state == TIMING), registered with the state.

## Timing
- Reset values:
  - bcd = 16'h0000, valid = 0, jump_start = 0, busy = 0.
  - Prescaler = 0, live counter = 0, s1/s2/s3 = 0, state = IDLE.
- Reset mid-operation clears everything asynchronously. No capture occurs, and the block waits for a fresh 8'hFF.
- Button latency: button first sampled high at edge E0 gives rise between E1 and E2. Capture, valid, and jump_start update at E2.
- Millisecond count: TIMING is entered at edge Et. The live count becomes k at edge Et + k·MS_DIV. A capture at edge Ec reports floor((Ec − Et − 1)/MS_DIV).
- valid is high for exactly one cycle per capture. There is never more than one capture per TIMING entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 immediately. After release, lights = 8'h00 and button toggling -> no valid.
- Normal run (MS_DIV=4):
  - lights steps 8'h01, 8'h03 … 8'hFF, then 8'h00 entering TIMING at edge Et.
  - Button timed so the capture edge is Et+150.
  - Expect bcd = 16'h0037, valid pulses 1 cycle, busy falls on the same edge.
- Jump start (MS_DIV=4):
  - lights = 8'hFF, button rise -> jump_start = 1, valid = 0, bcd unchanged.
  - Lights then 8'h00 -> stays IDLE, busy = 0.
  - Next 8'hFF clears jump_start.
- Saturation (MS_DIV=1):
  - Enter TIMING and wait more than 10000 cycles -> live count holds 9999.
  - Press -> bcd = 16'h9999, valid = 1.
- Abort and held button:
  - Button held high before ARMED, lights 8'hFF -> 8'h00 -> 8'h01 -> IDLE with no valid, bcd keeps the prior 16'h0037.
  - Release and re-press in IDLE -> ignored.
- Coincidence (MS_DIV=4):
  - Capture edge equals prescaler wrap at Et+8 -> bcd = 16'h0001, not 16'h0002.
